// File: rtl/sig_chk_pkg.sv
// Shared types and constants for the signature checkpoint monitor.
package sig_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PASS  = 2'd2,
        FAIL  = 2'd3
    } state_e;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_TMO   = 2'b01;
    localparam logic [1:0] FC_ORDER = 2'b10;
    localparam logic [1:0] FC_CFG   = 2'b11;

endpackage

// File: rtl/sig_chk_stable.sv
// Stability filter: pulses accept once match has held for STABLE_CYC consecutive cycles.
module sig_chk_stable #(
    parameter int STABLE_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic match,
    output logic accept
);

    localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;

    logic [CNT_W-1:0] cnt_r;

    assign accept = match && (cnt_r == CNT_W'(STABLE_CYC - 1));

    // Run-length counter of consecutive matching cycles; self-clears on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr || accept || !match) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sig_checkpoint_mon.sv
// Ordered-signature checkpoint monitor with cycle watchdog.
// Define SIG_ORDER_CHECK_EN to flag stable out-of-order signatures as a failure.
module sig_checkpoint_mon
    import sig_chk_pkg::*;
#(
    parameter int DW         = 16,
    parameter int NUM_CHK    = 4,
    parameter int TMO_W      = 24,
    parameter int STABLE_CYC = 2,
    parameter int IDX_W      = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1,
    parameter int CUR_W      = IDX_W + 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [DW-1:0]    cfg_sig,
    input  logic [CUR_W-1:0] cfg_num,
    input  logic [TMO_W-1:0] cfg_tmo,
    input  logic             start,
    input  logic             abort,
    input  logic [DW-1:0]    mon_data,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [CUR_W-1:0] cur_idx,
    output logic [TMO_W-1:0] elapsed
);

    state_e           state_r;
    logic [DW-1:0]    tbl_r [NUM_CHK];
    logic [CUR_W-1:0] num_r;
    logic [TMO_W-1:0] tmo_r;
    logic             busy_r, pass_r, fail_r;
    logic [1:0]       code_r;
    logic [CUR_W-1:0] cur_idx_r;
    logic [TMO_W-1:0] elapsed_r;

    logic             match_s, acc_s, ord_acc_s, clr_s, last_s, tmo_hit_s;
    logic [TMO_W-1:0] elapsed_inc_s;

    // In ARMED, cur_idx < num <= NUM_CHK, so the low bits address the table directly.
    assign match_s       = (mon_data == tbl_r[cur_idx_r[IDX_W-1:0]]);
    assign clr_s         = (state_r != ARMED) || abort;
    assign last_s        = ((cur_idx_r + CUR_W'(1)) == num_r);
    assign tmo_hit_s     = (tmo_r != {TMO_W{1'b0}}) && (elapsed_r == (tmo_r - TMO_W'(1)));
    assign elapsed_inc_s = (elapsed_r == {TMO_W{1'b1}}) ? elapsed_r : (elapsed_r + TMO_W'(1));

    sig_chk_stable #(.STABLE_CYC(STABLE_CYC)) u_stable (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (clr_s),
        .match  (match_s),
        .accept (acc_s)
    );

`ifdef SIG_ORDER_CHECK_EN
    logic ooo_s;

    // Current data equals a later, not-yet-reached entry while missing the expected one.
    always_comb begin
        ooo_s = 1'b0;
        for (int j = 0; j < NUM_CHK; j++) begin
            if ((j > int'(cur_idx_r)) && (j < int'(num_r)) && (mon_data == tbl_r[j]) && !match_s) begin
                ooo_s = 1'b1;
            end else begin
                ooo_s = ooo_s;
            end
        end
    end

    sig_chk_stable #(.STABLE_CYC(STABLE_CYC)) u_order (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (clr_s || acc_s),
        .match  (ooo_s),
        .accept (ord_acc_s)
    );
`else
    assign ord_acc_s = 1'b0;
`endif

    // Signature table; frozen while a sequence is being monitored.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NUM_CHK; i++) begin
                tbl_r[i] <= {DW{1'b0}};
            end
        end else if (cfg_we && !busy_r && (int'(cfg_idx) < NUM_CHK)) begin
            tbl_r[cfg_idx] <= cfg_sig;
        end
    end

    // Monitor FSM with registered status outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || abort) begin
            state_r   <= IDLE;
            num_r     <= {CUR_W{1'b0}};
            tmo_r     <= {TMO_W{1'b0}};
            busy_r    <= 1'b0;
            pass_r    <= 1'b0;
            fail_r    <= 1'b0;
            code_r    <= FC_NONE;
            cur_idx_r <= {CUR_W{1'b0}};
            elapsed_r <= {TMO_W{1'b0}};
        end else begin
            case (state_r)
                IDLE, PASS, FAIL: begin
                    if (start) begin
                        pass_r    <= 1'b0;
                        cur_idx_r <= {CUR_W{1'b0}};
                        elapsed_r <= {TMO_W{1'b0}};
                        if ((cfg_num == {CUR_W{1'b0}}) || (cfg_num > CUR_W'(NUM_CHK))) begin
                            state_r <= FAIL;
                            busy_r  <= 1'b0;
                            fail_r  <= 1'b1;
                            code_r  <= FC_CFG;
                        end else begin
                            state_r <= ARMED;
                            busy_r  <= 1'b1;
                            fail_r  <= 1'b0;
                            code_r  <= FC_NONE;
                            num_r   <= cfg_num;
                            tmo_r   <= cfg_tmo;
                        end
                    end
                end
                ARMED: begin
                    if (acc_s) begin
                        cur_idx_r <= cur_idx_r + CUR_W'(1);
                    end
                    // Final accept beats a coincident watchdog expiry; a timeout freezes elapsed.
                    if (acc_s && last_s) begin
                        state_r   <= PASS;
                        busy_r    <= 1'b0;
                        pass_r    <= 1'b1;
                        elapsed_r <= elapsed_inc_s;
                    end else if (tmo_hit_s) begin
                        state_r <= FAIL;
                        busy_r  <= 1'b0;
                        fail_r  <= 1'b1;
                        code_r  <= FC_TMO;
                    end else if (ord_acc_s) begin
                        state_r   <= FAIL;
                        busy_r    <= 1'b0;
                        fail_r    <= 1'b1;
                        code_r    <= FC_ORDER;
                        elapsed_r <= elapsed_inc_s;
                    end else begin
                        elapsed_r <= elapsed_inc_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign pass      = pass_r;
    assign fail      = fail_r;
    assign fail_code = code_r;
    assign cur_idx   = cur_idx_r;
    assign elapsed   = elapsed_r;

endmodule

// File: doc/sig_checkpoint_mon.md
Name: sig_checkpoint_mon

Overview:
- Synthesizable on-chip monitor that watches a DW-bit status bus (e.g. a slice of user GPIO driven by firmware) for an ordered sequence of up to NUM_CHK programmed signatures.
- A global cycle watchdog runs alongside; the block reports PASS, FAIL/timeout, progress index and elapsed cycles.
- Sits in the user project next to the BIST controller, so firmware-driven checkpoint tests are judged in hardware instead of by a simulation bench.

Parameters:
- DW, 16, width of monitored bus and of each signature
- NUM_CHK, 4, max checkpoints in sequence (>=1)
- TMO_W, 24, width of timeout limit and elapsed counter
- STABLE_CYC, 2, consecutive matching cycles needed to accept a checkpoint (>=1)

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- cfg_we  in  1  write strobe for signature table
- cfg_idx  in  $clog2(NUM_CHK)  table index written
- cfg_sig  in  DW  signature value written
- cfg_num  in  $clog2(NUM_CHK)+1  checkpoints used (1..NUM_CHK); sampled at start
- cfg_tmo  in  TMO_W  timeout limit in cycles; 0 disables watchdog; sampled at start
- start  in  1  one-cycle pulse: arm monitor
- abort  in  1  return to IDLE, clear status
- mon_data  in  DW  monitored bus
- busy  out  1  ARMED state
- pass  out  1  sticky pass
- fail  out  1  sticky fail
- fail_code  out  2  00 none, 01 timeout, 10 out-of-order, 11 bad config
- cur_idx  out  $clog2(NUM_CHK)+1  checkpoints accepted so far
- elapsed  out  TMO_W  cycles since start; frozen at PASS/FAIL

Behaviour:
- Reset: all outputs 0; signature table cleared to 0; state IDLE.
- Table write: cfg_we=1 writes cfg_sig to entry cfg_idx on the next edge; writes are ignored while busy; cfg_idx >= NUM_CHK is ignored.
- States are IDLE, ARMED, PASS, FAIL.
- IDLE/PASS/FAIL + start:
  - cfg_num==0 or >NUM_CHK -> FAIL with code 11 on the next cycle.
  - Otherwise -> ARMED; latch cfg_num and cfg_tmo; clear pass, fail, cur_idx, elapsed and the stability counter.
- ARMED:
  - elapsed increments each cycle, saturating at all-ones.
  - mon_data == table[cur_idx] increments the stability counter; any mismatch resets it to 0.
  - When the counter reaches STABLE_CYC, cur_idx increments and the counter clears. Latency from the first matching cycle is STABLE_CYC cycles.
  - When cur_idx reaches the latched num -> PASS (pass=1, busy=0), in the same edge as the final accept.
  - Timeout: latched tmo!=0 and elapsed == tmo-1 with no PASS on that edge -> FAIL, code 01. PASS on the same edge as timeout wins.
- Repeated consecutive identical signatures: after an accept, the counter clears. The next entry equal to the current data is therefore accepted after a further STABLE_CYC cycles.
- abort has priority over start and over all ARMED transitions: -> IDLE, outputs cleared; the table is kept.
- start while ARMED is ignored.
- wb_rst_i mid-operation: immediate return to reset values at the next edge.
- elapsed reports the count at the terminal edge and holds it until the next start or abort.

Optional Feature:
- Macro: SIG_ORDER_CHECK_EN
- Defined, in ARMED: mon_data equal to any table[j] with cur_idx < j < latched num, and not equal to table[cur_idx], for STABLE_CYC consecutive cycles -> FAIL, code 10.
- Undefined: such values count as mismatches; code 10 is never produced.

Decomposition:
- Package sig_chk_pkg holds:
  - state enum (IDLE, ARMED, PASS, FAIL)
  - fail_code localparams (FC_NONE, FC_TMO, FC_ORDER, FC_CFG)
- One natural sub-module: sig_chk_stable, a per-compare stability counter (match in, accept pulse out, clear in). It is instantiated once, or twice with SIG_ORDER_CHECK_EN.

Test Plan:
- Pass path: table {AB60, AB61}, num=2, tmo=1000, STABLE_CYC=2; drive AB60 for 3 cycles, then AB61 for 2 -> pass=1, cur_idx=2, fail=0, elapsed frozen at 5.
- Timeout: table {AB60, AB61}, tmo=50; drive only AB60 -> fail=1, code 01, cur_idx=1, elapsed=49.
- Glitch rejection: AB60 for 1 cycle, then 0000, then AB60 for 2 cycles -> accept only after the second burst; cur_idx goes 0->1 on cycle 4.
- Bad config and abort:
  - start with cfg_num=0 -> fail code 11 next cycle.
  - abort mid-ARMED -> all outputs 0; a subsequent start reuses the retained table and passes.
- Order check (macro on): table {0001, 0002, 0003}; drive 0003 for 2 cycles at cur_idx=0 -> fail code 10. Macro off: same stimulus -> no fail, timeout later.
- Priority: final accept and timeout on the same edge -> pass=1, fail=0. wb_rst_i asserted while ARMED -> all outputs 0 next cycle.
